// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control handshake and strobe bundle between sequencer and datapath
interface cpu_sequencer_if;
    logic        I_halt;
    logic        I_mem_ready;
    logic        I_is_mem;
    logic [2:0]  O_state;
    logic        O_fetch_en;
    logic        O_dec_en;
    logic        O_reg_en;
    logic        O_alu_en;
    logic        O_mem_en;
    logic        O_wb_en;
    logic        O_pc_inc;
    logic        O_halted;
    logic        O_fault;
    logic [15:0] O_inst_count;

    // Sequencer side: samples requests, drives stage strobes
    modport master (
        input  I_halt, I_mem_ready, I_is_mem,
        output O_state, O_fetch_en, O_dec_en, O_reg_en, O_alu_en, O_mem_en,
               O_wb_en, O_pc_inc, O_halted, O_fault, O_inst_count
    );

    // Datapath side: drives requests, consumes stage strobes
    modport slave (
        output I_halt, I_mem_ready, I_is_mem,
        input  O_state, O_fetch_en, O_dec_en, O_reg_en, O_alu_en, O_mem_en,
               O_wb_en, O_pc_inc, O_halted, O_fault, O_inst_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer with wait-state timeout
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            I_clk,
    input  logic            I_rst,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REGREAD = 3'd3,
        S_ALU     = 3'd4,
        S_MEM     = 3'd5,
        S_WB      = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  outs;       // {fetch, dec, reg, alu, mem, wb, pc_inc, halted}
    logic        fault;
    logic [15:0] inst_count;
    logic [7:0]  wait_cnt;

    // Strobe pattern for a state; registered together with the state so every
    // output comes straight from a flop.
    function automatic logic [7:0] dec_outs(input state_t s);
        case (s)
            S_FETCH:   dec_outs = 8'b1000_0000;
            S_DECODE:  dec_outs = 8'b0100_0000;
            S_REGREAD: dec_outs = 8'b0010_0000;
            S_ALU:     dec_outs = 8'b0001_0000;
            S_MEM:     dec_outs = 8'b0000_1000;
            S_WB:      dec_outs = 8'b0000_0110;
            S_HALT:    dec_outs = 8'b0000_0001;
            default:   dec_outs = 8'b0000_0000;
        endcase
    endfunction

    // Sequencer state, wait counter, fault flag and retirement counter
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= S_IDLE;
            outs       <= 8'd0;
            fault      <= 1'b0;
            inst_count <= 16'd0;
            wait_cnt   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.I_halt) begin
                        state <= S_HALT;
                        outs  <= dec_outs(S_HALT);
                    end else begin
                        state    <= S_FETCH;
                        outs     <= dec_outs(S_FETCH);
                        wait_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (bus.I_mem_ready) begin
                        // Ready wins even on the final allowed wait cycle
                        state    <= S_DECODE;
                        outs     <= dec_outs(S_DECODE);
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                        outs  <= dec_outs(S_HALT);
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    state <= S_REGREAD;
                    outs  <= dec_outs(S_REGREAD);
                end
                S_REGREAD: begin
                    state <= S_ALU;
                    outs  <= dec_outs(S_ALU);
                end
                S_ALU: begin
                    if (bus.I_is_mem) begin
                        state    <= S_MEM;
                        outs     <= dec_outs(S_MEM);
                        wait_cnt <= 8'd0;
                    end else begin
                        state <= S_WB;
                        outs  <= dec_outs(S_WB);
                    end
                end
                S_MEM: begin
                    if (bus.I_mem_ready) begin
                        state    <= S_WB;
                        outs     <= dec_outs(S_WB);
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                        outs  <= dec_outs(S_HALT);
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    // Retirement is counted on the edge leaving writeback
                    inst_count <= inst_count + 16'd1;
                    if (bus.I_halt) begin
                        state <= S_HALT;
                        outs  <= dec_outs(S_HALT);
                    end else begin
                        state    <= S_FETCH;
                        outs     <= dec_outs(S_FETCH);
                        wait_cnt <= 8'd0;
                    end
                end
                S_HALT: begin
                    // A fault makes HALT terminal until reset
                    if (!fault && !bus.I_halt) begin
                        state    <= S_FETCH;
                        outs     <= dec_outs(S_FETCH);
                        wait_cnt <= 8'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= 8'd0;
                end
            endcase
        end
    end

    assign bus.O_state      = state;
    assign bus.O_fetch_en   = outs[7];
    assign bus.O_dec_en     = outs[6];
    assign bus.O_reg_en     = outs[5];
    assign bus.O_alu_en     = outs[4];
    assign bus.O_mem_en     = outs[3];
    assign bus.O_wb_en      = outs[2];
    assign bus.O_pc_inc     = outs[1];
    assign bus.O_halted     = outs[0];
    assign bus.O_fault      = fault;
    assign bus.O_inst_count = inst_count;

endmodule
